// File: rtl/mux_n_pipe.sv
// Registered N:1 word multiplexer with valid/ready handshakes on every channel,
// explicit-select or round-robin arbitration, and a wrapping transfer counter.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16,
  localparam int SELW  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    Mode,
  input  logic [SELW-1:0]         Select,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_count
);

  localparam logic [SELW:0]   NUM_IN_W = (SELW+1)'(NUM_IN);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NUM_IN - 1);

  logic             active_q,    active_d;
  logic             outValid_q,  outValid_d;
  logic [WIDTH-1:0] outData_q,   outData_d;
  logic [SELW-1:0]  outSrc_q,    outSrc_d;
  logic [CNT_W-1:0] xferCount_q, xferCount_d;
  logic [SELW-1:0]  rrLast_q,    rrLast_d;

  logic             canLoad;
  logic             grantValid;
  logic [SELW-1:0]  grantIdx;
  logic [WIDTH-1:0] grantData;
  logic             xfer;

  assign canLoad = !outValid_q || out_ready;

  // Round-robin scan runs from farthest to nearest so the nearest valid
  // channel after rrLast_q is the last assignment and wins.
  always_comb begin
    logic [SELW-1:0] cand;
    cand       = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    if (!Mode) begin
      if ({1'b0, Select} < NUM_IN_W) begin
        grantValid = 1'b1;
        grantIdx   = Select;
      end
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        cand = SELW'((int'(rrLast_q) + k) % NUM_IN);
        if (in_valid[cand]) begin
          grantValid = 1'b1;
          grantIdx   = cand;
        end
      end
    end
  end

  always_comb begin
    grantData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grantIdx == SELW'(i)) grantData = in_data[i*WIDTH +: WIDTH];
    end
  end

  // active_q keeps all ready low during reset and on the first edge after it.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = active_q && canLoad && grantValid && (grantIdx == SELW'(i));
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_comb begin
    active_d    = 1'b1;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outSrc_d    = outSrc_q;
    xferCount_d = xferCount_q;
    rrLast_d    = rrLast_q;
    if (xfer) begin
      outValid_d  = 1'b1;
      outData_d   = grantData;
      outSrc_d    = grantIdx;
      xferCount_d = xferCount_q + CNT_W'(1);
      if (Mode) rrLast_d = grantIdx;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSrc_q    <= '0;
      xferCount_q <= '0;
      rrLast_q    <= LAST_CH;
    end else begin
      active_q    <= active_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outSrc_q    <= outSrc_d;
      xferCount_q <= xferCount_d;
      rrLast_q    <= rrLast_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_src    = outSrc_q;
  assign xfer_count = xferCount_q;

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised, registered N:1 word multiplexer with valid/ready handshakes on every input and on the output. It generalises the team's 32-bit 2:1 select mux to NUM_IN inputs of WIDTH bits. It adds two selection modes: explicit select and round-robin arbitration. It sits between multiple producers and one consumer in the datapath and counts transferred words.

Parameters:
WIDTH, 32, data width per input and output.
NUM_IN, 4, number of input channels; legal range 2 to 16.
CNT_W, 16, width of the transfer counter.
SELW, derived as clog2(NUM_IN) (minimum 1), select/source index width; not overridden.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_data  input  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  NUM_IN  per-channel valid.
in_ready  output  NUM_IN  per-channel ready.
Mode  input  1  0 = explicit select; 1 = round-robin.
Select  input  SELW  channel index used in Mode 0.
out_data  output  WIDTH  registered output word.
out_src  output  SELW  channel index that supplied out_data.
out_valid  output  1  output word valid.
out_ready  input  1  consumer ready.
xfer_count  output  CNT_W  number of input transfers accepted since reset.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n); asserting reset_n=0 immediately clears state.
  - Values forced by reset: out_valid=0, out_data=0, out_src=0, xfer_count=0, round-robin pointer rr_last=NUM_IN-1 (channel 0 has first priority).
  - Reset mid-transfer discards any held word. No transfer occurs in the cycle reset deasserts.
- can_load = !out_valid || out_ready. The output register is a single entry, so full throughput of 1 word per cycle is possible.
- Grant, combinational:
  - Mode 0: grant = Select if Select < NUM_IN; otherwise no grant.
  - Mode 1: grant = first index j with in_valid[j]=1, scanning rr_last+1, rr_last+2, ... and wrapping modulo NUM_IN. No grant if no valid input.
- in_ready[i] = can_load && (grant exists) && (i == grant); all other in_ready bits are 0.
  - In Mode 0, in_ready[Select] may be 1 while in_valid[Select]=0.
  - In Mode 1, in_ready depends combinationally on in_valid.
- Transfer on a rising edge when in_valid[g] && in_ready[g]. On transfer:
  - out_data <= channel g word; out_src <= g; out_valid <= 1.
  - xfer_count <= xfer_count + 1, wrapping from 2^CNT_W-1 to 0.
  - In Mode 1 only, rr_last <= g.
- No transfer and out_ready=1 with out_valid=1: out_valid <= 0 at that edge.
- Latency: 1 cycle from the input handshake to out_valid.
- While out_valid && !out_ready, out_data and out_src are held stable and all in_ready are 0.
- Mode or Select may change on any cycle; the change takes effect the same cycle. rr_last is retained across mode changes and is not updated in Mode 0.
- Select >= NUM_IN (only possible when NUM_IN is not a power of 2): no grant, no transfer, in_ready all 0. The output still drains normally.
- Simultaneous drain and load: out_ready=1 with a new transfer gives back-to-back valid words with no bubble.
- Bit-level selection has no X propagation: unselected channels never affect out_data.

Test Plan:
- Reset values: hold reset_n=0 with all inputs toggling -> out_valid=0, out_data=0, out_src=0, xfer_count=0, in_ready=0000.
- Explicit select (WIDTH=32, NUM_IN=4): Mode=0, Select=2, in_valid=0100, ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2, xfer_count=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch2 valid with 0x12345678 -> out_data holds its prior word, in_ready=0000. out_ready=1 -> 0x12345678 appears the following cycle.
- Round-robin fairness: Mode=1, in_valid=1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one word per cycle. Then in_valid=1010 -> alternates 1,3.
- Invalid select and counter wrap: NUM_IN=3, Select=3 -> in_ready=000, no transfers. CNT_W=4 with 17 transfers -> xfer_count=1.
- Reset mid-operation: assert reset_n=0 while out_valid=1 and out_ready=0 -> out_valid drops immediately. After release in Mode 1 with in_valid=1111 -> first out_src=0.
